// File: rtl/mul4_fitness_scorer_if.sv
// Bus bundle for the fitness scorer: run control, vector handshake, candidate outputs and result.
interface mul4_fitness_scorer_if;
  logic        start;
  logic [7:0]  num_vec;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a1, a0, b1, b0;
  logic [15:0] y3, y2, y1, y0;
  logic        busy;
  logic        done;
  logic [15:0] score;
  logic        perfect;

  modport master (
    output start, num_vec, in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
    input  in_ready, busy, done, score, perfect
  );

  modport slave (
    input  start, num_vec, in_valid, a1, a0, b1, b0, y3, y2, y1, y0,
    output in_ready, busy, done, score, perfect
  );
endinterface

// File: rtl/mul4_fitness_scorer.sv
// Scores a candidate 2x2-bit multiplier over a run of bit-sliced vectors:
// counts output bits matching the golden product through a 2-stage pipeline.
module mul4_fitness_scorer (
  input logic                  clk,
  input logic                  rst_n,
  mul4_fitness_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  num_lat;
  logic [7:0]  count;
  logic        drain_cnt;
  logic [63:0] match_q;
  logic        match_valid;
  logic [15:0] score_q;
  logic        perfect_q;

  logic        start_accept;
  logic        ready;
  logic        accept;
  logic        last_accept;
  logic [15:0] p3, p2, p1, p0;
  logic [63:0] match;
  logic [6:0]  pop;

  assign p0 = bus.a0 & bus.b0;
  assign p1 = (bus.a1 & bus.b0) ^ (bus.a0 & bus.b1);
  assign p2 = bus.a1 & bus.b1 & ~(bus.a0 & bus.b0);
  assign p3 = bus.a1 & bus.a0 & bus.b1 & bus.b0;
  assign match = ~({bus.y3, bus.y2, bus.y1, bus.y0} ^ {p3, p2, p1, p0});

  // An empty run never raises in_ready, so no vector can slip in.
  assign start_accept = (state == IDLE) && bus.start;
  assign ready        = (state == RUN) && (num_lat != 8'd0);
  assign accept       = ready && bus.in_valid;
  assign last_accept  = accept && (({1'b0, count} + 9'd1) == {1'b0, num_lat});

  always_comb begin
    pop = '0;
    for (int i = 0; i < 64; i++) begin
      pop = pop + {6'd0, match_q[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if ((num_lat == 8'd0) || last_accept) next_state = DRAIN;
      DRAIN:   if (drain_cnt) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat   <= '0;
      count     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_accept) begin
        num_lat <= bus.num_vec;
        count   <= '0;
      end else if (accept) begin
        count <= count + 8'd1;
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Stage 1 captures the match vector; stage 2 folds its popcount into score.
  // perfect is settled on the last DRAIN edge, when score is already final.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q     <= '0;
      match_valid <= 1'b0;
      score_q     <= '0;
      perfect_q   <= 1'b0;
    end else begin
      match_valid <= accept;
      if (accept) begin
        match_q <= match;
      end
      if (start_accept) begin
        score_q   <= '0;
        perfect_q <= 1'b0;
      end else begin
        if (match_valid) begin
          score_q <= score_q + {9'd0, pop};
        end
        if ((state == DRAIN) && drain_cnt) begin
          perfect_q <= (num_lat != 8'd0) && (score_q == {2'b00, num_lat, 6'b000000});
        end
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.busy     = (state == RUN) || (state == DRAIN);
  assign bus.done     = (state == DONE);
  assign bus.score    = score_q;
  assign bus.perfect  = perfect_q;

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// Directed bench for mul4_fitness_scorer: expected results are queued per run
// and a negedge monitor checks them, plus the done latency and accept count.
module tb_mul4_fitness_scorer;

  typedef struct {
    int score;
    int perfect;
    int accepts;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;
  exp_t exp_q[$];

  mul4_fitness_scorer_if bus ();

  mul4_fitness_scorer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference product built from integer multiplication of each lane.
  function automatic logic [63:0] golden(input logic [15:0] a1, a0, b1, b0);
    logic [3:0]  pr;
    logic [3:0]  av;
    logic [3:0]  bv;
    logic [15:0] q3, q2, q1, q0;
    for (int i = 0; i < 16; i++) begin
      av = {2'b00, a1[i], a0[i]};
      bv = {2'b00, b1[i], b0[i]};
      pr = av * bv;
      q0[i] = pr[0];
      q1[i] = pr[1];
      q2[i] = pr[2];
      q3[i] = pr[3];
    end
    return {q3, q2, q1, q0};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [7:0] n, input int s, input int p, input int acc, input int lat);
    exp_t e;
    e.score   = s;
    e.perfect = p;
    e.accepts = acc;
    e.lat     = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.num_vec = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic send_vec(input logic [15:0] va1, va0, vb1, vb0, input logic [63:0] y);
    logic acc;
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.a1 = va1;
    bus.a0 = va0;
    bus.b1 = vb1;
    bus.b0 = vb0;
    {bus.y3, bus.y2, bus.y1, bus.y0} = y;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no in_ready, expected in_ready within 20 cycles");
    end
  endtask

  // mode 0: correct y, 1: inverted y, 2: all-zero y, 3: correct y with four p0 bits flipped
  task automatic apply_stimulus(input int mode, input logic [15:0] va1, va0, vb1, vb0);
    logic [63:0] g;
    logic [63:0] y;
    g = golden(va1, va0, vb1, vb0);
    case (mode)
      0:       y = g;
      1:       y = ~g;
      2:       y = '0;
      default: y = g ^ 64'h0000_0000_0000_000F;
    endcase
    send_vec(va1, va0, vb1, vb0, y);
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", budget);
    end
  endtask

  // Monitor: tracks the reference cycle for done latency and scores each done.
  initial begin
    int   ref_cyc;
    int   run_acc;
    exp_t e;
    cyc     = 0;
    ref_cyc = 0;
    run_acc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        run_acc = 0;
      end else begin
        if (bus.start && !bus.busy && !bus.done) begin
          ref_cyc = cyc;
          run_acc = 0;
        end
        if (bus.in_valid && bus.in_ready) begin
          ref_cyc = cyc;
          run_acc++;
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_done: got done=1, expected done=0 (score %0d)", bus.score);
          end else begin
            e = exp_q.pop_front();
            check_output("score", int'(bus.score), e.score);
            check_output("perfect", int'(bus.perfect), e.perfect);
            check_output("busy_with_done", int'(bus.busy), 0);
            check_output("accepts", run_acc, e.accepts);
            check_output("done_latency", cyc - ref_cyc, e.lat);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.num_vec = '0;
    bus.in_valid = 1'b0;
    bus.a1 = '0;
    bus.a0 = '0;
    bus.b1 = '0;
    bus.b0 = '0;
    {bus.y3, bus.y2, bus.y1, bus.y0} = '0;

    #12;
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_done", int'(bus.done), 0);
    check_output("rst_in_ready", int'(bus.in_ready), 0);
    check_output("rst_score", int'(bus.score), 0);
    check_output("rst_perfect", int'(bus.perfect), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Four random vectors with a correct candidate.
    start_run(8'd4, 256, 1, 4, 3);
    for (int v = 0; v < 4; v++) begin
      apply_stimulus(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    wait_done(20);
    idle(1);

    // Fully inverted candidate scores nothing.
    start_run(8'd1, 0, 0, 1, 3);
    apply_stimulus(1, 16'h3C5A, 16'h0FF0, 16'hA5C3, 16'h1234);
    wait_done(20);
    idle(1);

    // 3x3=9 in every lane, y=0: only p2 and p1 match, 32 bits per vector.
    start_run(8'd2, 64, 0, 2, 3);
    apply_stimulus(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    apply_stimulus(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done(20);
    idle(5);
    check_output("score_hold", int'(bus.score), 64);
    check_output("perfect_hold", int'(bus.perfect), 0);

    // Empty run: in_valid held high but nothing may be accepted.
    bus.in_valid = 1'b1;
    start_run(8'd0, 0, 0, 0, 4);
    wait_done(20);
    bus.in_valid = 1'b0;
    idle(1);

    // Gapped vectors with a stray start mid-run: 64 + 60 + 64.
    start_run(8'd3, 188, 0, 3, 3);
    apply_stimulus(0, 16'h1111, 16'h2222, 16'h4444, 16'h8888);
    idle(2);
    bus.start   = 1'b1;
    bus.num_vec = 8'd7;
    idle(1);
    bus.start = 1'b0;
    idle(1);
    apply_stimulus(3, 16'hF0F0, 16'hCCCC, 16'hAAAA, 16'h5555);
    idle(3);
    apply_stimulus(0, 16'h0F0F, 16'h3333, 16'h5555, 16'hAAAA);
    wait_done(20);
    idle(1);

    // Reset in the middle of a five-vector run.
    start_run(8'd5, 0, 0, 0, 0);
    apply_stimulus(0, 16'h1357, 16'h2468, 16'h9BDF, 16'hACE0);
    apply_stimulus(0, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210);
    idle(3);
    check_output("score_mid_run", int'(bus.score), 128);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_busy", int'(bus.busy), 0);
    check_output("midrst_done", int'(bus.done), 0);
    check_output("midrst_in_ready", int'(bus.in_ready), 0);
    check_output("midrst_score", int'(bus.score), 0);
    check_output("midrst_perfect", int'(bus.perfect), 0);
    idle(2);
    rst_n = 1'b1;
    idle(8);

    start_run(8'd1, 64, 1, 1, 3);
    apply_stimulus(0, 16'h6789, 16'hABCD, 16'hEF01, 16'h2345);
    wait_done(20);
    idle(3);

    check_output("pending_results", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
